// File: rtl/instr_fetch_issue_if.sv
// instr_fetch_issue_if: memory fetch bus plus decoder-side issue signals
interface instr_fetch_issue_if #(
  parameter int ADDR_W = 16
);
  logic en;
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0] op;
  logic [31:0] instr;
  logic instr_valid;
  logic stall;
  logic branch;
  logic alu_zero;
  logic [ADDR_W-1:0] pc;
  modport master (
    input en, imem_ack, imem_rdata, stall, branch, alu_zero,
    output imem_req, imem_addr, op, instr, instr_valid, pc
  );
  modport slave (
    output en, imem_ack, imem_rdata, stall, branch, alu_zero,
    input imem_req, imem_addr, op, instr, instr_valid, pc
  );
endinterface

// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: fetches one instruction at a time over req/ack and issues it to the decoder
module instr_fetch_issue #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst_n,
  instr_fetch_issue_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] next_pc;
  logic [31:0] instr;
  logic [4:0] op;
  logic req;
  logic valid;
  assign offset = ADDR_W'({{14{instr[15]}}, instr[15:0], 2'b00});
  assign pc_inc = pc + ADDR_W'(4);
  assign next_pc = (bus.branch & bus.alu_zero) ? pc_inc + offset : pc_inc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= '0;
      op <= '0;
      req <= 1'b0;
      valid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.en) begin
            state <= REQ;
            req <= 1'b1;
          end
        REQ:
          if (bus.imem_ack) begin
            instr <= bus.imem_rdata;
            op <= bus.imem_rdata[31:27];
            req <= 1'b0;
            valid <= 1'b1;
            state <= ISSUE;
          end
        ISSUE:
          if (!bus.stall) begin
            pc <= next_pc;
            valid <= 1'b0;
            req <= bus.en;
            state <= bus.en ? REQ : IDLE;
          end
        default: state <= IDLE;
      endcase
  assign bus.imem_req = req;
  assign bus.imem_addr = pc;
  assign bus.instr = instr;
  assign bus.op = op;
  assign bus.instr_valid = valid;
  assign bus.pc = pc;
endmodule
